debug_host_link: RTL

DEBUG_HOST_LINK -- requirements
Module: debug_host_link

---
 rtl/dbg_pkg.sv | 17 +
 rtl/frame_assembler.sv | 49 ++++
 rtl/debug_host_link.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug host link: FSM state encoding and the
// command bytes understood by the target's debug monitor.
package dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_RECV    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_RUN  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

endpackage

// File: rtl/frame_assembler.sv
// Collects response bytes into a shadow register and publishes the whole
// frame to frame_data only when the last byte arrives.
module frame_assembler #(
    parameter int N_BYTES = 177
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   store,
    input  logic [7:0]             rx_data,
    output logic                   frame_last,
    output logic [8*N_BYTES-1:0]   frame_data
);

    localparam int CNT_W = $clog2(N_BYTES + 1);

    logic [CNT_W-1:0]     count;
    logic [8*N_BYTES-1:0] shadow;
    logic [8*N_BYTES-1:0] shadow_next;

    always_comb begin
        shadow_next = shadow;
        if (count < CNT_W'(N_BYTES)) begin
            shadow_next[8*int'(count) +: 8] = rx_data;
        end
    end

    assign frame_last = store && (count == CNT_W'(N_BYTES - 1));

    // frame_data is loaded from shadow_next so the last byte and the
    // commit land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            shadow     <= '0;
            frame_data <= '0;
        end else if (clear) begin
            count  <= '0;
            shadow <= '0;
        end else if (store) begin
            count  <= count + CNT_W'(1);
            shadow <= shadow_next;
            if (frame_last) begin
                frame_data <= shadow_next;
            end
        end
    end

endmodule

// File: rtl/debug_host_link.sv
// Sends one command byte to the debug UART and optionally gathers an
// N_BYTES response frame. Define DEBUG_HOST_LINK_TIMEOUT_EN for a response timeout.
module debug_host_link
    import dbg_pkg::*;
#(
    parameter int N_BYTES     = 177,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [7:0]             cmd_byte,
    input  logic                   cmd_expect,
    output logic                   cmd_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done_tick,
    input  logic                   rx_done_tick,
    input  logic [7:0]             rx_data,
    output logic [8*N_BYTES-1:0]   frame_data,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   timeout_err
);

    if (N_BYTES < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("debug_host_link: N_BYTES and TIMEOUT_CYC must be at least 1");
    end

    state_t state;
    logic   expect_q;
    logic   store;
    logic   clear;
    logic   frame_last;
    logic   tmo_hit;

    assign store = (state == ST_RECV) && rx_done_tick;
    assign clear = (state != ST_RECV);

    frame_assembler #(
        .N_BYTES (N_BYTES)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .store      (store),
        .rx_data    (rx_data),
        .frame_last (frame_last),
        .frame_data (frame_data)
    );

`ifdef DEBUG_HOST_LINK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] tmr;
    logic             waiting;

    assign waiting = (state == ST_WAIT_TX) || (state == ST_RECV);

    // tmr holds the number of the current silent cycle, so it is loaded with
    // 1 on activity and timeout_err lands in silent cycle TIMEOUT_CYC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else if (!waiting || tx_done_tick || rx_done_tick) begin
            tmr <= TMR_W'(1);
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    assign tmo_hit = waiting && !tx_done_tick && !rx_done_tick
                     && (tmr >= TMR_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            expect_q    <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            tx_start    <= 1'b0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        tx_data   <= cmd_byte;
                        expect_q  <= cmd_expect;
                        tx_start  <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done_tick) begin
                        if (expect_q) begin
                            state <= ST_RECV;
                        end else begin
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (frame_last) begin
                        frame_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
